fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage pipeline. It generates the word address for the synchronous-read instruction ROM (one-cycle read latency) and tracks which PC each returned word belongs to. It also applies stall and branch/jump redirects, detects a halt word, and drives the IF/ID pipeline register consumed by decode.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, word address of the first fetch after reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high; also drives the ROM's rst
- stall_i  in  1  hazard unit: hold PC and IF/ID
- redirect_i  in  1  EX: taken branch/jump this cycle
- redirect_pc_i  in  32  redirect target, word address
- pc_address  out  32  combinational word address to ROM, sampled by ROM at next edge
- instruction_code  in  32  ROM data, corresponds to address presented one cycle earlier
- id_valid_o  out  1  IF/ID holds a live instruction
- id_instr_o  out  32  IF/ID instruction
- id_pc_o  out  32  IF/ID PC
- id_pc_plus1_o  out  32  IF/ID PC+1
- halted_o  out  1  state is HALT

## Operation
- Word-addressed PC: sequential next = PC+1, modulo 2^32 (0xFFFF_FFFF+1 = 0).
- Internal regs: fpc_q (PC of word currently on instruction_code), fvld_q (that word is on the correct path), state.
- States: BOOT, RUN, HALT. BOOT→RUN after exactly one cycle. RUN→HALT on halt detect. HALT exits only via rst.
- pc_address:
  - rst or BOOT: RESET_PC.
  - RUN: redirect_i ? redirect_pc_i : stall_i ? fpc_q : fpc_q+1.
  - HALT: fpc_q.
- Stall re-presents fpc_q so the ROM re-reads the same word; no skid buffer.
- Edge actions, in priority order:
  - rst: state=BOOT, fpc_q=RESET_PC, fvld_q=0, all id_* outputs 0.
  - BOOT: fpc_q=RESET_PC, fvld_q=1, state=RUN. IF/ID loads nothing (ROM output is its reset 0).
  - RUN, redirect_i (wins over stall_i): fpc_q=redirect_pc_i, fvld_q=1, id_valid_o=0. The word on instruction_code is wrong-path and is dropped.
  - RUN, stall_i: all registers hold.
  - RUN, normal:
    - id_instr_o=instruction_code, id_pc_o=fpc_q, id_pc_plus1_o=fpc_q+1, id_valid_o=fvld_q.
    - fpc_q=fpc_q+1, fvld_q=1.
    - If fvld_q and instruction_code==HALT_WORD: state=HALT, fvld_q=0. The halt word itself enters IF/ID valid.
  - HALT: stall_i holds IF/ID; otherwise id_valid_o=0. redirect_i is ignored.
- Invalid IF/ID entries keep id_instr_o/id_pc_o at the last loaded values. Decode must gate on id_valid_o.

## Timing
- Reset values: id_valid_o=0, id_instr_o=0, id_pc_o=0, id_pc_plus1_o=0, halted_o=0, pc_address=RESET_PC.
- Fetch latency: address presented in cycle n → word on instruction_code in n+1 → IF/ID outputs in n+2.
- After rst deasserts:
  - cycle 0: BOOT.
  - cycle 1: word RESET_PC on instruction_code.
  - cycle 2: id_valid_o=1, id_pc_o=RESET_PC.
- Redirect penalty: one fetch bubble. id_valid_o=0 for exactly one cycle, then the target reaches IF/ID the next cycle.
- Stall for k cycles: outputs frozen k cycles. On release, fetch resumes with no loss or duplication.
- rst mid-operation overrides everything in the same edge.
- pc_address has a combinational path from stall_i/redirect_i/redirect_pc_i.

## Structure
- Shared package fetch_pkg: fetch_state_e {BOOT, RUN, HALT}, PC_W=32, INSTR_W=32, NOP_INSTR=32'h0.
- One sub-module: if_id_reg (load/hold/flush register for valid, instr, pc, pc_plus1). Hold has priority below flush; both apply on the same edge.

## Test plan
ROM preloaded with word[a] = 32'h1000_0000+a; word[6] = HALT_WORD.
- Reset, release, no stall → id_valid_o rises 2 cycles after release with id_pc_o=0, id_instr_o=32'h1000_0000, then PCs 1, 2, 3 on consecutive cycles.
- stall_i high 3 cycles while id_pc_o=2 → id_* frozen at PC 2 for 3 cycles, next cycle PC 3; no skipped or repeated PC.
- redirect_i with redirect_pc_i=20 while id_pc_o=2 → next cycle id_valid_o=0, following cycle id_pc_o=20, id_instr_o=32'h1000_0014.
- redirect_i and stall_i together → redirect wins: same response as the previous case.
- Sequential run reaching PC 6 → IF/ID gets HALT_WORD with valid=1, then id_valid_o=0 permanently, halted_o=1. A later redirect has no effect.
- rst pulse mid-stream at PC 4, stall high → all outputs zero next cycle, restart from PC 0 as in the first case.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and widths for the instruction-fetch stage
package fetch_pkg;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// rtl/fetch_unit_if_id_reg.sv - IF/ID pipeline register with load, hold and flush
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [PC_W-1:0]    pc_plus1_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1
);

  // Flush only drops valid; payload keeps the last loaded values for debug visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      instr    <= NOP_INSTR;
      pc       <= '0;
      pc_plus1 <= '0;
    end else if (flush) begin
      valid    <= 1'b0;
    end else if (!hold) begin
      valid    <= valid_in;
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus1 <= pc_plus1_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC generation, ROM address, redirect/stall/halt handling and IF/ID
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    pc_address,
  input  logic [INSTR_W-1:0] instruction_code,
  output logic               id_valid_o,
  output logic [INSTR_W-1:0] id_instr_o,
  output logic [PC_W-1:0]    id_pc_o,
  output logic [PC_W-1:0]    id_pc_plus1_o,
  output logic               halted_o
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic             fvld_q, fvld_d;
  logic             id_hold, id_flush;
  logic [PC_W-1:0]  fpc_inc;

  assign fpc_inc = fpc_q + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      fpc_q   <= RESET_PC;
      fvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      fvld_q  <= fvld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    fvld_d     = fvld_q;
    id_hold    = 1'b0;
    id_flush   = 1'b0;
    pc_address = fpc_q;
    case (state_q)
      BOOT: begin
        pc_address = RESET_PC;
        fpc_d      = RESET_PC;
        fvld_d     = 1'b1;
        state_d    = RUN;
        id_flush   = 1'b1;
      end
      RUN: begin
        if (redirect_i) begin
          // The word now on instruction_code is wrong-path; drop it.
          pc_address = redirect_pc_i;
          fpc_d      = redirect_pc_i;
          fvld_d     = 1'b1;
          id_flush   = 1'b1;
        end else if (stall_i) begin
          pc_address = fpc_q;
          id_hold    = 1'b1;
        end else begin
          pc_address = fpc_inc;
          fpc_d      = fpc_inc;
          fvld_d     = 1'b1;
          if (fvld_q && instruction_code == HALT_WORD) begin
            state_d = HALT;
            fvld_d  = 1'b0;
          end
        end
      end
      HALT: begin
        pc_address = fpc_q;
        id_hold    = stall_i;
        id_flush   = !stall_i;
      end
      default: begin
        state_d  = BOOT;
        id_flush = 1'b1;
      end
    endcase
    if (rst) pc_address = RESET_PC;
  end

  assign halted_o = (state_q == HALT);

  if_id_reg u_if_id (
    .clk         (clk),
    .rst         (rst),
    .hold        (id_hold),
    .flush       (id_flush),
    .valid_in    (fvld_q),
    .instr_in    (instruction_code),
    .pc_in       (fpc_q),
    .pc_plus1_in (fpc_inc),
    .valid       (id_valid_o),
    .instr       (id_instr_o),
    .pc          (id_pc_o),
    .pc_plus1    (id_pc_plus1_o)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit against a program-order fetch model
module tb_fetch_unit;

  localparam logic [31:0] HALT_W  = 32'hFFFF_FFFF;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc1;
    logic        h;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_address;
  logic [31:0] instruction_code;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus1_o;
  logic        halted_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] addr_q[$];
  snap_t       id_q[$];

  // Reference state: next PC to reach decode in program order.
  logic [31:0] m_next;
  logic        m_boot;
  logic        m_halted;
  snap_t       m_snap;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .HALT_WORD(HALT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_address       (pc_address),
    .instruction_code (instruction_code),
    .id_valid_o       (id_valid_o),
    .id_instr_o       (id_instr_o),
    .id_pc_o          (id_pc_o),
    .id_pc_plus1_o    (id_pc_plus1_o),
    .halted_o         (halted_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'd6) ? HALT_W : 32'h1000_0000 + a;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) instruction_code <= '0;
    else     instruction_code <= rom_word(pc_address);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (addr_q.size() > 0) cmp("pc_address", pc_address, addr_q.pop_front());
  end

  always @(posedge clk) begin
    snap_t e;
    #1;
    if (id_q.size() > 0) begin
      e = id_q.pop_front();
      cmp("id_valid", {31'd0, id_valid_o}, {31'd0, e.v});
      cmp("halted", {31'd0, halted_o}, {31'd0, e.h});
      if (e.v) begin
        cmp("id_instr", id_instr_o, e.instr);
        cmp("id_pc", id_pc_o, e.pc);
        cmp("id_pc_plus1", id_pc_plus1_o, e.pc1);
      end
    end
  end

  // Drive one cycle of stimulus, derive what the DUT must show, then advance.
  task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
    logic [31:0] a;
    rst = r; stall_i = s; redirect_i = d; redirect_pc_i = t;
    if (r) begin
      a = RST_PC;
      m_snap = '{1'b0, 32'd0, 32'd0, 32'd0, 1'b0};
      m_next = RST_PC; m_boot = 1'b1; m_halted = 1'b0;
    end else if (m_boot) begin
      a = RST_PC;
      m_snap.v = 1'b0;
      m_boot = 1'b0;
    end else if (m_halted) begin
      a = m_next;
      if (!s) m_snap.v = 1'b0;
    end else if (d) begin
      a = t;
      m_snap.v = 1'b0;
      m_next = t;
    end else if (s) begin
      a = m_next;
    end else begin
      a = m_next + 32'd1;
      m_snap = '{1'b1, rom_word(m_next), m_next, m_next + 32'd1, 1'b0};
      if (rom_word(m_next) == HALT_W) m_halted = 1'b1;
      m_next = m_next + 32'd1;
    end
    m_snap.h = m_halted;
    addr_q.push_back(a);
    id_q.push_back(m_snap);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [31:0] tgt;
    @(posedge clk); #2;
    // Boot and sequential fetch, then a 3-cycle stall.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    run(4);
    repeat (3) step(0, 1, 0, 0);
    run(2);
    // Redirect to 20 while PC 2 sits in IF/ID.
    step(1, 0, 0, 0); run(4);
    step(0, 0, 1, 32'd20); run(3);
    // Redirect together with stall.
    step(1, 0, 0, 0); run(4);
    step(0, 1, 1, 32'd20); run(3);
    // Sequential run into the halt word, then an ignored redirect and a stall.
    step(1, 0, 0, 0); run(10);
    step(0, 0, 1, 32'd3); run(2);
    step(0, 1, 0, 0); run(2);
    // Reset mid-stream at PC 4 with stall held high.
    step(1, 0, 0, 0); run(6);
    step(1, 1, 0, 0); run(5);
    // PC wrap-around.
    step(1, 0, 0, 0); run(3);
    step(0, 0, 1, 32'hFFFF_FFFE); run(5);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom_range(0, 6);
        1:       tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: tgt = $urandom_range(7, 60);
      endcase
      step(r < 3, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt);
    end
    step(0, 0, 0, 0);
    #10;
    n_cmp++;
    if (addr_q.size() != 0 || id_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", addr_q.size(), id_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
